// File: rtl/answer_period.sv
// answer_period: answer window, grading, score and result display for one game round.
// Define SCORE_PENALTY_EN to make a wrong or timed-out grade decrement the score.
module answer_period #(
  parameter int ANSWER_SECS = 10,
  parameter int SHOW_SECS = 3,
  parameter int MAX_GUESS = 99
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       tick1Hz,
  input  logic       answerSig,
  input  logic [7:0] numSpecial,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnSubmit,
  output logic       answerActive,
  output logic       resultValid,
  output logic       correct,
  output logic       timedOut,
  output logic       roundDone,
  output logic [7:0] score,
  output logic [7:0] ansSeg0,
  output logic [7:0] ansSeg1,
  output logic [7:0] ansSeg2,
  output logic [7:0] ansSeg3
);
  typedef enum logic [1:0] {IDLE, ANSWER, CHECK, SHOW} state_t;
  state_t state;
  logic [6:0] guess, target;
  logic [7:0] sec_cnt;
  logic [3:0] g_tens, g_units, t_tens, t_units;
  logic hit;
  function automatic logic [7:0] seg7(input logic [3:0] d);
    return d == 4'd0 ? 8'hC0 : d == 4'd1 ? 8'hF9 : d == 4'd2 ? 8'hA4 :
           d == 4'd3 ? 8'hB0 : d == 4'd4 ? 8'h99 : d == 4'd5 ? 8'h92 :
           d == 4'd6 ? 8'h82 : d == 4'd7 ? 8'hF8 : d == 4'd8 ? 8'h80 :
           d == 4'd9 ? 8'h90 : 8'hFF;
  endfunction
  always_comb begin
    g_tens = 4'(guess / 7'd10);
    g_units = 4'(guess % 7'd10);
    t_tens = 4'(target / 7'd10);
    t_units = 4'(target % 7'd10);
    hit = guess == target;
  end
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state <= IDLE;
      answerActive <= 1'b0;
      resultValid <= 1'b0;
      correct <= 1'b0;
      timedOut <= 1'b0;
      roundDone <= 1'b0;
      score <= 8'd0;
      guess <= 7'd0;
      target <= 7'd0;
      sec_cnt <= 8'd0;
      {ansSeg3, ansSeg2, ansSeg1, ansSeg0} <= 32'hFFFF_FFFF;
    end else begin
      roundDone <= 1'b0;
      case (state)
        IDLE: begin
          {ansSeg3, ansSeg2, ansSeg1, ansSeg0} <= 32'hFFFF_FFFF;
          if (answerSig) begin
            target <= numSpecial > 8'(MAX_GUESS) ? 7'(MAX_GUESS) : numSpecial[6:0];
            guess <= 7'd0;
            sec_cnt <= 8'd0;
            correct <= 1'b0;
            timedOut <= 1'b0;
            answerActive <= 1'b1;
            state <= ANSWER;
          end
        end
        ANSWER: begin
          {ansSeg3, ansSeg2, ansSeg1, ansSeg0} <= {16'hFFFF, seg7(g_tens), seg7(g_units)};
          if (btnSubmit) begin
            timedOut <= 1'b0;
            answerActive <= 1'b0;
            state <= CHECK;
          end else if (tick1Hz && sec_cnt == 8'(ANSWER_SECS - 1)) begin
            timedOut <= 1'b1;
            answerActive <= 1'b0;
            state <= CHECK;
          end else begin
            if (btnUp && !btnDown && guess != 7'(MAX_GUESS)) guess <= guess + 7'd1;
            if (btnDown && !btnUp && guess != 7'd0) guess <= guess - 7'd1;
            if (tick1Hz) sec_cnt <= sec_cnt + 8'd1;
          end
        end
        CHECK: begin
          correct <= hit;
          if (hit && score != 8'hFF) score <= score + 8'd1;
`ifdef SCORE_PENALTY_EN
          else if (!hit && score != 8'h00) score <= score - 8'd1;
`endif
          sec_cnt <= 8'd0;
          resultValid <= 1'b1;
          {ansSeg3, ansSeg2, ansSeg1, ansSeg0} <= {hit ? 8'hC6 : 8'h8E, 8'hFF, seg7(t_tens), seg7(t_units)};
          state <= SHOW;
        end
        SHOW: begin
          if (tick1Hz) begin
            if (sec_cnt == 8'(SHOW_SECS - 1)) begin
              resultValid <= 1'b0;
              roundDone <= 1'b1;
              {ansSeg3, ansSeg2, ansSeg1, ansSeg0} <= 32'hFFFF_FFFF;
              state <= IDLE;
            end else sec_cnt <= sec_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_answer_period.sv
// tb_answer_period: directed rounds with a result scoreboard checked by a separate monitor.
module tb_answer_period;
  logic Clk100M = 1'b0, Reset = 1'b1;
  logic tick1Hz = 1'b0, answerSig = 1'b0, btnUp = 1'b0, btnDown = 1'b0, btnSubmit = 1'b0;
  logic [7:0] numSpecial = 8'd0;
  logic answerActive, resultValid, correct, timedOut, roundDone;
  logic [7:0] score, ansSeg0, ansSeg1, ansSeg2, ansSeg3;
  typedef struct packed {
    logic c;
    logic t;
    logic [7:0] s;
    logic [31:0] seg;
  } exp_t;
  exp_t q[$];
  int checks = 0, passes = 0, rd_cnt = 0;
  logic [7:0] exp_score = 8'd0;
  logic rv_prev = 1'b0;
  answer_period dut (
    .Clk100M(Clk100M), .Reset(Reset), .tick1Hz(tick1Hz), .answerSig(answerSig),
    .numSpecial(numSpecial), .btnUp(btnUp), .btnDown(btnDown), .btnSubmit(btnSubmit),
    .answerActive(answerActive), .resultValid(resultValid), .correct(correct),
    .timedOut(timedOut), .roundDone(roundDone), .score(score),
    .ansSeg0(ansSeg0), .ansSeg1(ansSeg1), .ansSeg2(ansSeg2), .ansSeg3(ansSeg3)
  );
  always #5 Clk100M = ~Clk100M;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask
  task automatic pulse(input logic u, input logic d, input logic s, input logic t, input logic a);
    {btnUp, btnDown, btnSubmit, tick1Hz, answerSig} = {u, d, s, t, a};
    @(posedge Clk100M);
    #1 {btnUp, btnDown, btnSubmit, tick1Hz, answerSig} = 5'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge Clk100M);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(0, 0, 0, 1, 0);
      idle(1);
    end
  endtask
  task automatic expect_round(input logic c, input logic t, input logic [7:0] tgt_seg1, input logic [7:0] tgt_seg0);
    if (c && exp_score != 8'hFF) exp_score = exp_score + 8'd1;
`ifdef SCORE_PENALTY_EN
    else if (!c && exp_score != 8'h00) exp_score = exp_score - 8'd1;
`endif
    q.push_back('{c: c, t: t, s: exp_score, seg: {c ? 8'hC6 : 8'h8E, 8'hFF, tgt_seg1, tgt_seg0}});
  endtask
  always @(negedge Clk100M) begin
    if (roundDone) rd_cnt++;
    if (resultValid && !rv_prev && !Reset) begin
      if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("correct", {31'd0, correct}, {31'd0, e.c});
        chk("timedOut", {31'd0, timedOut}, {31'd0, e.t});
        chk("score", {24'd0, score}, {24'd0, e.s});
        chk("result_segs", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, e.seg);
      end
    end
    rv_prev <= resultValid;
  end
  initial begin
    idle(3);
    Reset = 1'b0;
    chk("reset_flags", {27'd0, answerActive, resultValid, correct, timedOut, roundDone}, 32'd0);
    chk("reset_score", {24'd0, score}, 32'd0);
    chk("reset_segs", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, 32'hFFFF_FFFF);
    // Round 1: target 3, guess 3, submit
    numSpecial = 8'd3;
    pulse(0, 0, 0, 0, 1);
    chk("answer_active", {31'd0, answerActive}, 32'd1);
    repeat (3) pulse(1, 0, 0, 0, 0);
    idle(2);
    chk("guess3_segs", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, 32'hFFFF_C0B0);
    expect_round(1, 0, 8'hC0, 8'hB0);
    pulse(0, 0, 1, 0, 0);
    idle(2);
    ticks(2);
    pulse(0, 0, 0, 1, 0);
    chk("round_done_pulse", {29'd0, roundDone, answerActive, resultValid}, 32'd4);
    idle(1);
    chk("round_done_single", {31'd0, roundDone}, 32'd0);
    // Round 2: target 5, timeout after 10 ticks
    numSpecial = 8'd5;
    pulse(0, 0, 0, 0, 1);
    expect_round(0, 1, 8'hC0, 8'h92);
    ticks(10);
    idle(2);
    ticks(3);
    // Round 3: target saturates at 99, guess saturation both ways
    numSpecial = 8'd200;
    pulse(0, 0, 0, 0, 1);
    repeat (105) pulse(1, 0, 0, 0, 0);
    idle(2);
    chk("guess_sat_hi", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, 32'hFFFF_9090);
    repeat (110) pulse(0, 1, 0, 0, 0);
    idle(2);
    chk("guess_sat_lo", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, 32'hFFFF_C0C0);
    repeat (5) pulse(1, 0, 0, 0, 0);
    pulse(1, 1, 0, 0, 0);
    idle(2);
    chk("up_down_same", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, 32'hFFFF_C092);
    repeat (94) pulse(1, 0, 0, 0, 0);
    numSpecial = 8'd7;
    pulse(0, 0, 0, 0, 1);
    idle(2);
    chk("guess99_segs", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, 32'hFFFF_9090);
    expect_round(1, 0, 8'h90, 8'h90);
    pulse(0, 0, 1, 0, 0);
    idle(2);
    numSpecial = 8'd1;
    pulse(0, 0, 0, 0, 1);
    idle(1);
    chk("show_ignores_answersig", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, 32'hC6FF_9090);
    ticks(3);
    // Round 4: submit coincident with the final tick
    numSpecial = 8'd0;
    pulse(0, 0, 0, 0, 1);
    ticks(9);
    expect_round(1, 0, 8'hC0, 8'hC0);
    pulse(0, 0, 1, 1, 0);
    idle(2);
    ticks(3);
    chk("score_before_reset", {24'd0, score}, {24'd0, exp_score});
    // Reset mid-ANSWER
    numSpecial = 8'd4;
    pulse(0, 0, 0, 0, 1);
    repeat (2) pulse(1, 0, 0, 0, 0);
    idle(2);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    chk("midreset_flags", {27'd0, answerActive, resultValid, correct, timedOut, roundDone}, 32'd0);
    chk("midreset_score", {24'd0, score}, 32'd0);
    chk("midreset_segs", {ansSeg3, ansSeg2, ansSeg1, ansSeg0}, 32'hFFFF_FFFF);
    idle(3);
    chk("round_done_count", rd_cnt, 32'd4);
    chk("results_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
